// File: rtl/paddsb_seq.sv
// Lane-serial packed saturating add/subtract: one LANE_W-bit lane per cycle through a shared adder.
// Optional sticky saturation flags are enabled with `define PADDSB_SEQ_STICKY_EN.
module paddsb_seq #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op,
  input  logic [LANE_W*LANES-1:0]  a,
  input  logic [LANE_W*LANES-1:0]  b,
  output logic [LANE_W*LANES-1:0]  sum,
  output logic [LANES-1:0]         sat_mask,
  output logic                     busy,
  output logic                     done
`ifdef PADDSB_SEQ_STICKY_EN
  ,
  input  logic                     sticky_clr,
  output logic [LANES-1:0]         sat_sticky
`endif
);

  localparam int DW    = LANE_W * LANES;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DW-1:0]      r_a;
  logic [DW-1:0]      r_b;
  logic               r_op;
  logic [IDX_W-1:0]   r_idx;
  logic [DW-1:0]      r_work;
  logic [LANES-1:0]   r_wmask;
  logic [DW-1:0]      r_sum;
  logic [LANES-1:0]   r_mask;

  logic               w_accept;
  logic               w_last;
  logic [LANE_W-1:0]  w_a_lane;
  logic [LANE_W-1:0]  w_b_lane;
  logic [LANE_W:0]    w_x;
  logic [LANE_W:0]    w_y;
  logic [LANE_W:0]    w_r;
  logic               w_ovf_pos;
  logic               w_ovf_neg;
  logic [LANE_W-1:0]  w_lane;
  logic [DW-1:0]      w_work_next;
  logic [LANES-1:0]   w_wmask_next;

  // start is honoured only when the unit is idle or just finishing.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_idx == IDX_W'(LANES - 1));

  // Shared lane adder in LANE_W+1 bits; subtract is x + ~y + 1 so b = min is exact.
  assign w_a_lane  = r_a[r_idx*LANE_W +: LANE_W];
  assign w_b_lane  = r_b[r_idx*LANE_W +: LANE_W];
  assign w_x       = {w_a_lane[LANE_W-1], w_a_lane};
  assign w_y       = r_op ? ~{w_b_lane[LANE_W-1], w_b_lane} : {w_b_lane[LANE_W-1], w_b_lane};
  assign w_r       = w_x + w_y + {{LANE_W{1'b0}}, r_op};
  assign w_ovf_pos = ~w_r[LANE_W] &  w_r[LANE_W-1];
  assign w_ovf_neg =  w_r[LANE_W] & ~w_r[LANE_W-1];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_lane = w_r[LANE_W-1:0];
    if (w_ovf_pos)
      w_lane = {1'b0, {(LANE_W-1){1'b1}}};
    else if (w_ovf_neg)
      w_lane = {1'b1, {(LANE_W-1){1'b0}}};
  end

  always_comb begin
    w_work_next                        = r_work;
    w_work_next[r_idx*LANE_W +: LANE_W] = w_lane;
    w_wmask_next                       = r_wmask;
    w_wmask_next[r_idx]                = w_ovf_pos | w_ovf_neg;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_work  <= '0;
      r_wmask <= '0;
      r_sum   <= '0;
      r_mask  <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_op    <= op;
        r_idx   <= '0;
        r_work  <= '0;
        r_wmask <= '0;
      end else if (r_state == S_RUN) begin
        r_work  <= w_work_next;
        r_wmask <= w_wmask_next;
        if (!w_last)
          r_idx <= r_idx + IDX_W'(1);
      end
      // Results only move on completion, so sum/sat_mask are stable throughout RUN.
      if (w_last) begin
        r_sum  <= w_work_next;
        r_mask <= w_wmask_next;
      end
    end
  end

`ifdef PADDSB_SEQ_STICKY_EN
  logic [LANES-1:0] r_sticky;

  // A clear coinciding with completion keeps only the new mask: clear first, then OR.
  always_ff @(posedge clk) begin
    if (rst)
      r_sticky <= '0;
    else if (w_last)
      r_sticky <= (sticky_clr ? '0 : r_sticky) | w_wmask_next;
    else if (sticky_clr)
      r_sticky <= '0;
  end

  assign sat_sticky = r_sticky;
`endif

  assign sum      = r_sum;
  assign sat_mask = r_mask;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

endmodule

// File: doc/paddsb_seq.md
Name: paddsb_seq

Overview:
- Parametrised, lane-serial packed saturating add/subtract unit. Successor to the fixed 4x4-bit packed saturating adder.
- Processes one LANE_W-bit lane per cycle through a single shared adder, under a start/done handshake.
- Sits in the EX stage as a multi-cycle functional unit. The pipeline stalls on busy.

Parameters:
LANE_W, 4, bits per lane (>=2)
LANES, 4, number of lanes (>=1); data width DW = LANE_W*LANES

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
op  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start
a  input  DW  packed operand A; captured with start
b  input  DW  packed operand B; captured with start
sum  output  DW  packed saturated result; registered
sat_mask  output  LANES  bit i = 1 if lane i saturated; registered
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse, high while state is DONE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, sum=0, sat_mask=0, busy=0, done=0, lane index=0, operand/working registers=0. rst has priority over every other input.
- FSM states are IDLE, RUN and DONE.
  - IDLE: start=1 captures a, b, op into internal registers, clears the working result and mask, sets idx=0, and moves to RUN. start=0 stays in IDLE.
  - RUN: each cycle computes lane idx and writes it into working result bits [idx*LANE_W +: LANE_W] and working mask bit idx.
    - idx<LANES-1: idx increments and the FSM stays in RUN.
    - idx==LANES-1: the completed working result/mask, including this lane, load into sum/sat_mask, and the FSM moves to DONE.
    - start is ignored in RUN. No queueing.
- DONE: done=1 for exactly one cycle.
  - start=1 in this cycle is accepted as in IDLE (back-to-back; FSM goes to RUN).
  - Otherwise the FSM goes to IDLE.
- Latency: start high in cycle T gives RUN in cycles T+1..T+LANES and done high in cycle T+LANES+1. sum/sat_mask are valid from that cycle.
- sum/sat_mask hold their value until the next completion. They do not change during RUN.
- Lane arithmetic is signed two's complement in LANE_W+1 bits, with x = sign-extended a lane and y = sign-extended b lane.
  - r = x+y for op=0; r = x-y for op=1, computed as x + ~y + 1 so that b lane = min is handled exactly.
  - If r > 2^(LANE_W-1)-1: lane = 0 followed by all ones (max positive), mask bit = 1.
  - If r < -2^(LANE_W-1): lane = 1 followed by all zeros (min negative), mask bit = 1.
  - Else lane = r[LANE_W-1:0], mask bit = 0.
- Lanes are independent: no carry between lanes.
- Reset mid-operation (rst in RUN or DONE) returns to IDLE, clears all outputs, and abandons the partial result.
- LANES=1: RUN lasts one cycle, and done is seen 2 cycles after start.

Optional Feature:
- Macro PADDSB_SEQ_STICKY_EN.
- Defined: adds input sticky_clr (1 bit) and output sat_sticky (LANES bits).
  - On each completion, sat_sticky <= sat_sticky | new sat_mask.
  - sticky_clr=1 clears sat_sticky to 0. If sticky_clr coincides with a completion, sat_sticky takes the new sat_mask only (clear first, then OR).
  - Reset value 0.
- Undefined: neither port exists and no sticky state is synthesised. All other behaviour is identical.

Test Plan:
- Defaults, op=0, a=0x5A3C, b=0x3C9D, start pulse -> busy for 4 cycles, then done one cycle with sum=0x78C9, sat_mask=4'b1100.
- Defaults, op=1, a=0x7080, b=0x8181 -> sum=0x7F0F, sat_mask=4'b1000 (lane3 7-(-8) clamps to 0x7; lane1 -8-(-8)=0, no saturation).
- LANE_W=8, LANES=2, op=1, a=0x807F, b=0x0101 -> done 3 cycles after start, sum=0x807E, sat_mask=2'b10.
- Back-to-back: second start (op=0, a=0x1111, b=0x2222) asserted in the DONE cycle -> accepted with no IDLE gap, done 5 cycles later, sum=0x3333, sat_mask=0. A start pulse during RUN is ignored and produces no extra done.
- Reset mid-op: assert rst in the 2nd RUN cycle -> next cycle state=IDLE, busy=0, done=0, sum=0, sat_mask=0. No done pulse follows.
- With PADDSB_SEQ_STICKY_EN: op1 saturates lane3 then op2 saturates lane0 -> sat_sticky=4'b1001. sticky_clr -> 0. sticky_clr in the same cycle as the op2 completion -> sat_sticky=4'b0001.
